// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants and FSM state encoding for the ALU datapath.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;
   localparam int WIDTH = 16;
   localparam int CNT_W = 5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_CALC = ST_CALC,
      S_DONE = ST_DONE
   } state_e;
endpackage

`default_nettype wire

// File: rtl/rca16bit.sv
// ============================================================================
//  Module      : RCA16bit
//  Description : 16-bit ripple-carry adder with carry-in and carry-out.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module RCA16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);
   logic [16:0] w_carry;

   assign w_carry[0] = cin;

   for (genvar i = 0; i < 16; i++) begin : g_bit
      assign sum[i]         = a[i] ^ b[i] ^ w_carry[i];
      assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
   end

   assign cout = w_carry[16];
endmodule

`default_nettype wire

// File: rtl/seq_mult16.sv
// ============================================================================
//  Module      : seq_mult16
//  Description : Sequential 16x16 unsigned shift-and-add multiplier with
//                valid/ready handshakes, 32-bit product and overflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_mult16 #(
   parameter int WIDTH = alu_pkg::WIDTH,
   parameter int CNT_W = alu_pkg::CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] prod,
   output logic               ovf,
   output logic               busy
);
   import alu_pkg::*;

   if (WIDTH != 16) begin : g_bad_width
      $error("seq_mult16: only WIDTH=16 is supported");
   end
   if (CNT_W < $clog2(WIDTH) + 1) begin : g_bad_cnt_w
      $error("seq_mult16: CNT_W too small for WIDTH");
   end

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic               ovf_q, ovf_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   logic [WIDTH-1:0]   w_add_b;
   logic [WIDTH-1:0]   w_add_sum;
   logic               w_add_cout;

   assign w_add_b = lo_q[0] ? mcand_q : '0;

   RCA16bit u_adder (
      .a    (hi_q),
      .b    (w_add_b),
      .cin  (1'b0),
      .sum  (w_add_sum),
      .cout (w_add_cout)
   );

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      ovf_d   = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               mcand_d = a;
               lo_d    = b;
               hi_d    = '0;
               cnt_d   = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            // Shift the 33-bit {cout,sum,lo} right; cout becomes the new hi MSB.
            hi_d  = {w_add_cout, w_add_sum[WIDTH-1:1]};
            lo_d  = {w_add_sum[0], lo_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == C_LAST) begin
               prod_d  = {hi_d, lo_d};
               ovf_d   = |hi_d;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d == S_CALC);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mcand_q     <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         cnt_q       <= '0;
         prod_q      <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         cnt_q       <= cnt_d;
         prod_q      <= prod_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign prod      = prod_q;
   assign ovf       = ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_seq_mult16.sv
// ============================================================================
//  Module      : tb_seq_mult16
//  Description : Self-checking bench for seq_mult16 against an a*b reference.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_mult16;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] prod;
   logic        ovf;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_mult16 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .prod      (prod),
      .ovf       (ovf),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the result handshake.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input int stall,
                         input bit hold_next, input logic [15:0] na, input logic [15:0] nb);
      logic [31:0] exp_p;
      logic        exp_o;
      int          t;
      int          lat;
      exp_p = 32'(ta) * 32'(tbv);
      exp_o = (exp_p > 32'h0000_FFFF);
      a = ta; b = tbv; in_valid = 1'b1; out_ready = 1'b0;
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("accept_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (hold_next) begin
         a = na; b = nb; in_valid = 1'b1;
      end else begin
         a = 16'($urandom); b = 16'($urandom); in_valid = 1'b0;
      end
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 32'd16);
      check("prod", prod, exp_p);
      check("ovf", {31'b0, ovf}, {31'b0, exp_o});
      repeat (stall) begin
         @(negedge clk);
         check("prod_hold", prod, exp_p);
         check("ovf_hold", {31'b0, ovf}, {31'b0, exp_o});
         check("valid_hold", {31'b0, out_valid}, 32'd1);
         check("in_ready_done", {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("valid_drop", {31'b0, out_valid}, 32'd0);
      check("in_ready_back", {31'b0, in_ready}, 32'd1);
      check("prod_idle", prod, exp_p);
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("rst_prod", prod, 32'd0);
      check("rst_ovf", {31'b0, ovf}, 32'd0);
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(16'h0003, 16'h0005, 0, 1'b0, 16'h0, 16'h0);
      run_op(16'hFFFF, 16'hFFFF, 2, 1'b0, 16'h0, 16'h0);
      run_op(16'h1234, 16'h0000, 0, 1'b0, 16'h0, 16'h0);
      run_op(16'h0000, 16'hBEEF, 0, 1'b0, 16'h0, 16'h0);
      run_op(16'h0100, 16'h0100, 5, 1'b1, 16'h0002, 16'h0003);
      run_op(16'h0002, 16'h0003, 0, 1'b0, 16'h0, 16'h0);

      // Reset in the middle of a calculation.
      a = 16'h7777; b = 16'h9999; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      check("calc_busy", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      check("mid_rst_prod", prod, 32'd0);
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
      run_op(16'h00FF, 16'h0101, 0, 1'b0, 16'h0, 16'h0);

      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         case ($urandom_range(0, 7))
            0: ra = 16'hFFFF;
            1: rb = 16'h0000;
            2: begin ra = 16'hFFFF; rb = 16'hFFFF; end
            default: ;
         endcase
         run_op(ra, rb, int'($urandom_range(0, 3)), 1'b0, 16'h0, 16'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
